// File: rtl/wash_pkg.sv
// wash_pkg: shared FSM state encoding, counter width and default timing constants for the wash panel
package wash_pkg;
  typedef enum logic [2:0] {IDLE, LID_CHK, START, WAIT, RELEASE, BEEP, FAULT} state_t;
  localparam int CNT_W = 8;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF = 200;
  localparam int BEEP_CYCLES_DEF = 8;
endpackage

// File: rtl/wash_debounce.sv
// wash_debounce: 2-FF synchronizer plus stability counter (clk, rst, raw din -> debounced level dout)
module wash_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int W = $clog2(DEB_CYCLES + 1);
  logic s1, s2;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) cnt <= '0;
      else if (cnt == W'(DEB_CYCLES - 1)) begin
        dout <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/wash_panel_ctrl.sv
// wash_panel_ctrl: washer front panel (raw btn_coin/btn_double/sw_lid and washer done inputs -> coin_insert/double_wash/lid requests, busy/fault/beep/cycles_done status)
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int BEEP_CYCLES = BEEP_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_coin,
  input  logic             btn_double,
  input  logic             sw_lid,
  input  logic             laundry_done,
  input  logic             double_wash_done,
  input  logic             lid_done,
  output logic             coin_insert,
  output logic             double_wash,
  output logic             lid,
  output logic             busy,
  output logic             fault,
  output logic             beep,
  output logic [CNT_W-1:0] cycles_done
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic coin_db, coin_q, dbl_db, lid_db, coin_rise, dbl_sel, done, expired;
  logic [WW-1:0] wd;
  logic [BW-1:0] bc;
  state_t state, nxt;
  wash_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_coin (.clk(clk), .rst(rst), .din(btn_coin), .dout(coin_db));
  wash_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dbl (.clk(clk), .rst(rst), .din(btn_double), .dout(dbl_db));
  wash_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_lid (.clk(clk), .rst(rst), .din(sw_lid), .dout(lid_db));
  assign coin_rise = coin_db & ~coin_q;
  assign done = dbl_sel ? double_wash_done : laundry_done;
  assign expired = wd == WW'(TIMEOUT - 1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = coin_rise ? LID_CHK : IDLE;
      LID_CHK: nxt = lid_db ? START : expired ? FAULT : LID_CHK;
      START:   nxt = WAIT;
      WAIT:    nxt = !lid_db ? FAULT : done ? RELEASE : expired ? FAULT : WAIT;
      RELEASE: nxt = lid_done ? BEEP : expired ? FAULT : RELEASE;
      BEEP:    nxt = (bc == BW'(BEEP_CYCLES - 1)) ? IDLE : BEEP;
      default: nxt = FAULT;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      coin_q <= 1'b0;
      dbl_sel <= 1'b0;
      wd <= '0;
      bc <= '0;
      cycles_done <= '0;
      coin_insert <= 1'b0;
      double_wash <= 1'b0;
      lid <= 1'b0;
      busy <= 1'b0;
      fault <= 1'b0;
      beep <= 1'b0;
    end else begin
      state <= nxt;
      coin_q <= coin_db;
      dbl_sel <= (state == IDLE && coin_rise) ? dbl_db : dbl_sel;
      wd <= (nxt != state) ? '0 : (state inside {LID_CHK, WAIT, RELEASE}) ? wd + 1'b1 : wd;
      bc <= (nxt == BEEP && state == BEEP) ? bc + 1'b1 : '0;
      cycles_done <= (nxt == BEEP && state != BEEP && cycles_done != '1) ? cycles_done + 1'b1 : cycles_done;
      coin_insert <= nxt == START;
      lid <= nxt == START || nxt == WAIT;
      double_wash <= (nxt == START || nxt == WAIT) && dbl_sel;
      busy <= nxt != IDLE;
      fault <= nxt == FAULT;
      beep <= nxt == BEEP || nxt == FAULT;
    end
endmodule

// File: tb/tb_wash_panel_ctrl.sv
// tb_wash_panel_ctrl: randomized scoreboard bench for wash_panel_ctrl against a run-level outcome model
module tb_wash_panel_ctrl;
  localparam int DEB = 4, TIMEOUT = 200, BEEP = 8;
  localparam int K_OK = 0, K_NOLID = 1, K_OPEN = 2, K_HANG = 3;
  typedef struct {
    bit flt;
    bit dbl;
    int ins;
    int cnt;
    int wait_n;
    int busy_n;
    int beep_n;
  } exp_t;
  logic clk, rst, btn_coin, btn_double, sw_lid, laundry_done, double_wash_done, lid_done;
  logic coin_insert, double_wash, lid, busy, fault, beep;
  logic [7:0] cycles_done;
  int checks = 0, errors = 0, mcnt = 0;
  exp_t sb[$];
  exp_t cur;
  bit active = 0, pb = 0;
  int n_busy, n_wait, n_beep, n_ins;
  wash_panel_ctrl dut (
    .clk(clk), .rst(rst), .btn_coin(btn_coin), .btn_double(btn_double), .sw_lid(sw_lid),
    .laundry_done(laundry_done), .double_wash_done(double_wash_done), .lid_done(lid_done),
    .coin_insert(coin_insert), .double_wash(double_wash), .lid(lid), .busy(busy),
    .fault(fault), .beep(beep), .cycles_done(cycles_done)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      pb = 0;
    end else begin
      if (busy && !pb) begin
        chk("run_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          active = 1;
          n_busy = 0; n_wait = 0; n_beep = 0; n_ins = 0;
        end
      end
      if (active) begin
        n_ins += int'(coin_insert);
        n_busy += int'(busy && !fault);
        n_wait += int'(lid && !coin_insert);
        n_beep += int'(beep && !fault);
        chk("double_wash", int'(double_wash), int'(lid && cur.dbl));
        if (fault || !busy) begin
          chk("fault", int'(fault), int'(cur.flt));
          chk("cycles_done", int'(cycles_done), cur.cnt);
          chk("inserts", n_ins, cur.ins);
          chk("lid_end", int'(lid), 0);
          if (cur.wait_n >= 0) chk("wait_len", n_wait, cur.wait_n);
          if (cur.busy_n >= 0) chk("lidchk_len", n_busy, cur.busy_n);
          if (cur.beep_n >= 0) chk("beep_len", n_beep, cur.beep_n);
          active = 0;
        end
      end else chk("idle_insert", int'(coin_insert), 0);
      pb = busy;
    end
  end
  task automatic pulse(input bit ld, input bit dd, input bit lidd);
    laundry_done = ld; double_wash_done = dd; lid_done = lidd;
    @(negedge clk);
    laundry_done = 0; double_wash_done = 0; lid_done = 0;
  endtask
  task automatic do_reset;
    @(negedge clk);
    #2 rst = 1;
    #1 chk("reset_outputs", int'({coin_insert, double_wash, lid, busy, fault, beep, cycles_done}), 0);
    mcnt = 0;
    sb.delete();
    @(negedge clk);
    #2 rst = 0;
  endtask
  task automatic run(input int kind, input bit dbl, input bit wrong, input bit bounce, input bit extra, input bit abort);
    exp_t e;
    int d, t;
    d = $urandom_range(8, 30);
    btn_double = dbl; sw_lid = (kind != K_NOLID); btn_coin = 0;
    repeat (10) @(negedge clk);
    if (kind == K_OK && !abort) mcnt = (mcnt == 255) ? 255 : mcnt + 1;
    e = '{flt: kind != K_OK, dbl: dbl, ins: int'(kind != K_NOLID), cnt: mcnt,
          wait_n: kind == K_OK ? d + (wrong ? 3 : 0) : kind == K_HANG ? TIMEOUT : -1,
          busy_n: kind == K_NOLID ? TIMEOUT : -1, beep_n: kind == K_OK ? BEEP : -1};
    sb.push_back(e);
    if (bounce) for (int i = 0; i < 20; i++) begin btn_coin = ~btn_coin; @(negedge clk); end
    btn_coin = 1;
    if (kind != K_NOLID) begin
      t = 0;
      while (!coin_insert && t < 60) begin @(negedge clk); t++; end
      chk("insert_seen", int'(coin_insert), 1);
      if (!bounce) chk("insert_latency", int'(t <= DEB + 6), 1);
      btn_coin = 0;
      btn_double = ~dbl;
    end
    if (kind == K_OK) begin
      repeat (d) @(negedge clk);
      if (wrong) begin
        pulse(dbl, !dbl, 1);
        repeat (2) @(negedge clk);
      end
      pulse(!dbl, dbl, 0);
      t = 0;
      while (lid && t < 20) begin @(negedge clk); t++; end
      chk("lid_release", int'(lid), 0);
      if (extra) btn_coin = 1;
      repeat (2) @(negedge clk);
      pulse(0, 0, 1);
      if (abort) begin
        t = 0;
        while (!beep && t < 20) begin @(negedge clk); t++; end
        chk("beep_seen", int'(beep), 1);
        do_reset;
        btn_coin = 0;
        return;
      end
      t = 0;
      while (busy && t < 40) begin @(negedge clk); t++; end
      chk("busy_fall", int'(busy), 0);
    end else begin
      if (kind == K_OPEN) begin
        repeat (5) @(negedge clk);
        sw_lid = 0;
      end
      t = 0;
      while (!fault && t < TIMEOUT + 40) begin @(negedge clk); t++; end
      chk("fault_rise", int'(fault), 1);
    end
    repeat (2) @(negedge clk);
    btn_coin = 0; btn_double = 0;
    if (kind != K_OK) begin
      repeat (10) @(negedge clk);
      btn_coin = 1;
      repeat (15) @(negedge clk);
      chk("fault_sticky", int'(fault), 1);
      btn_coin = 0;
      do_reset;
    end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
  initial begin
    rst = 1;
    {btn_coin, btn_double, sw_lid, laundry_done, double_wash_done, lid_done} = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({coin_insert, double_wash, lid, busy, fault, beep, cycles_done}), 0);
    #2 rst = 0;
    run(K_OK, 0, 0, 0, 0, 0);
    run(K_OK, 1, 1, 0, 0, 0);
    run(K_OK, 0, 1, 0, 0, 0);
    run(K_OK, 0, 0, 1, 1, 0);
    run(K_NOLID, 0, 0, 1, 0, 0);
    run(K_OPEN, 1, 0, 0, 0, 0);
    run(K_HANG, 0, 0, 0, 0, 0);
    run(K_OK, 1, 0, 0, 0, 1);
    for (int i = 0; i < 258; i++)
      run(K_OK, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 0);
    repeat (5) @(negedge clk);
    chk("saturated", int'(cycles_done), mcnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
